// File: rtl/stage_skid_reg_if.sv
// Handshake bundle between an upstream producer, the skid stage and the downstream consumer.
// The slave modport is the stage's view; master is the surrounding producer/consumer view.
interface stage_skid_reg_if #(
    parameter int PC_W   = 64,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_pc, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_data
    );

    modport slave (
        input  in_valid, in_pc, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_data
    );
endinterface

// File: rtl/stage_skid_reg.sv
// Pipeline stage register with a one-entry skid buffer.
// in_ready and all out_* come straight from flops, so no combinational path crosses the stage.
module stage_skid_reg #(
    parameter int              PC_W   = 64,
    parameter int              DATA_W = 128,
    parameter logic [PC_W-1:0] RST_PC = PC_W'(64'h8000_0000),
    parameter int              CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    stage_skid_reg_if.slave      bus,
    output logic [CNT_W-1:0]     stall_cnt
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [PC_W-1:0]   r_main_pc;
    logic [DATA_W-1:0] r_main_data;
    logic [PC_W-1:0]   r_skid_pc;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_stalled;

    assign w_stalled = r_out_valid & ~bus.out_ready;

    // Entry-tracking FSM; flush only resets the occupancy, never the payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_pc   <= RST_PC;
            r_main_data <= '0;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (bus.in_valid) begin
                        r_main_pc   <= bus.in_pc;
                        r_main_data <= bus.in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            r_main_pc   <= bus.in_pc;
                            r_main_data <= bus.in_data;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_EMPTY;
                        end
                    end else if (bus.in_valid) begin
                        r_skid_pc   <= bus.in_pc;
                        r_skid_data <= bus.in_data;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so anything offered upstream is not a transfer.
                    if (bus.out_ready) begin
                        r_main_pc   <= r_skid_pc;
                        r_main_data <= r_skid_data;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_FULL;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating back-pressure counter, deliberately unaffected by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pc    = r_main_pc;
    assign bus.out_data  = r_main_data;
    assign stall_cnt     = r_stall_cnt;
endmodule

// File: tb/tb_stage_skid_reg.sv
// Directed bench for stage_skid_reg: reset, streaming, skid, flush, counter saturation, reset-over-flush.
module tb_stage_skid_reg;
    localparam int PC_W   = 64;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    int               n_checks;
    int               n_fails;

    stage_skid_reg_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

    stage_skid_reg #(
        .PC_W  (PC_W),
        .DATA_W(DATA_W),
        .RST_PC(64'h0000_0000_8000_0000),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus.slave),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [63:0] pc, input logic [127:0] data);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_data  = data;
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        offer(1'b1, 64'h1111, 128'h1111);

        // reset held two cycles, with an entry offered that must be ignored
        tick();
        tick();
        chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst_out_pc", {64'd0, bus.out_pc}, 128'h8000_0000);
        chk("rst_out_data", bus.out_data, 128'd0);
        chk("rst_stall_cnt", {124'd0, stall_cnt}, 128'd0);
        chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
        rst = 1'b0;
        offer(1'b0, 64'd0, 128'd0);
        tick();
        chk("idle_out_valid", {127'd0, bus.out_valid}, 128'd0);

        // streaming, back-to-back
        bus.out_ready = 1'b1;
        offer(1'b1, 64'h8000_0000, 128'hD0);
        tick();
        chk("s0_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("s0_pc", {64'd0, bus.out_pc}, 128'h8000_0000);
        chk("s0_data", bus.out_data, 128'hD0);
        chk("s0_in_ready", {127'd0, bus.in_ready}, 128'd1);
        offer(1'b1, 64'h8000_0004, 128'hD1);
        tick();
        chk("s1_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("s1_pc", {64'd0, bus.out_pc}, 128'h8000_0004);
        chk("s1_in_ready", {127'd0, bus.in_ready}, 128'd1);
        offer(1'b1, 64'h8000_0008, 128'hD2);
        tick();
        chk("s2_pc", {64'd0, bus.out_pc}, 128'h8000_0008);
        chk("s2_data", bus.out_data, 128'hD2);
        offer(1'b0, 64'd0, 128'd0);
        tick();
        chk("drain_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("drain_pc_kept", {64'd0, bus.out_pc}, 128'h8000_0008);
        chk("drain_data_kept", bus.out_data, 128'hD2);
        chk("stream_stall", {124'd0, stall_cnt}, 128'd0);

        // skid: A held, B lands in skid while out_ready=0
        bus.out_ready = 1'b0;
        offer(1'b1, 64'h1000, 128'hA);
        tick();
        chk("a_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("a_pc", {64'd0, bus.out_pc}, 128'h1000);
        chk("a_stall", {124'd0, stall_cnt}, 128'd0);
        offer(1'b1, 64'h1004, 128'hB);
        tick();
        chk("skid_in_ready", {127'd0, bus.in_ready}, 128'd0);
        chk("skid_pc_a", {64'd0, bus.out_pc}, 128'h1000);
        chk("skid_stall1", {124'd0, stall_cnt}, 128'd1);
        offer(1'b1, 64'hDEAD, 128'hDEAD);
        tick();
        tick();
        tick();
        chk("hold_stall4", {124'd0, stall_cnt}, 128'd4);
        chk("hold_in_ready", {127'd0, bus.in_ready}, 128'd0);
        chk("hold_pc_a", {64'd0, bus.out_pc}, 128'h1000);
        chk("hold_data_a", bus.out_data, 128'hA);
        offer(1'b0, 64'd0, 128'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("b_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("b_pc", {64'd0, bus.out_pc}, 128'h1004);
        chk("b_data", bus.out_data, 128'hB);
        chk("b_in_ready", {127'd0, bus.in_ready}, 128'd1);
        tick();
        chk("ab_empty", {127'd0, bus.out_valid}, 128'd0);
        chk("ab_stall", {124'd0, stall_cnt}, 128'd4);

        // flush from SKID with C offered the same cycle
        bus.out_ready = 1'b0;
        offer(1'b1, 64'h2000, 128'hA2);
        tick();
        offer(1'b1, 64'h2004, 128'hB2);
        tick();
        chk("f_skid_in_ready", {127'd0, bus.in_ready}, 128'd0);
        chk("f_skid_stall", {124'd0, stall_cnt}, 128'd5);
        flush = 1'b1;
        offer(1'b1, 64'h3000, 128'hC);
        tick();
        chk("flush_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("flush_in_ready", {127'd0, bus.in_ready}, 128'd1);
        chk("flush_pc_kept", {64'd0, bus.out_pc}, 128'h2000);
        chk("flush_data_kept", bus.out_data, 128'hA2);
        chk("flush_stall", {124'd0, stall_cnt}, 128'd6);
        flush = 1'b0;
        offer(1'b0, 64'd0, 128'd0);
        tick();
        chk("postflush_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("postflush_pc", {64'd0, bus.out_pc}, 128'h2000);
        bus.out_ready = 1'b1;
        offer(1'b1, 64'h4000, 128'hD);
        tick();
        chk("d_pc", {64'd0, bus.out_pc}, 128'h4000);
        chk("d_data", bus.out_data, 128'hD);
        offer(1'b0, 64'd0, 128'd0);
        tick();
        chk("d_gone", {127'd0, bus.out_valid}, 128'd0);

        // counter saturation at 15 with CNT_W=4
        bus.out_ready = 1'b0;
        offer(1'b1, 64'h5000, 128'hE);
        tick();
        offer(1'b0, 64'd0, 128'd0);
        chk("sat_start", {124'd0, stall_cnt}, 128'd6);
        for (int i = 0; i < 8; i++) tick();
        chk("sat_14", {124'd0, stall_cnt}, 128'd14);
        for (int i = 0; i < 12; i++) tick();
        chk("sat_15", {124'd0, stall_cnt}, 128'd15);
        chk("sat_pc", {64'd0, bus.out_pc}, 128'h5000);

        // reset and flush together while FULL
        rst   = 1'b1;
        flush = 1'b1;
        offer(1'b1, 64'h6000, 128'hF);
        tick();
        chk("rf_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rf_in_ready", {127'd0, bus.in_ready}, 128'd1);
        chk("rf_pc", {64'd0, bus.out_pc}, 128'h8000_0000);
        chk("rf_data", bus.out_data, 128'd0);
        chk("rf_stall", {124'd0, stall_cnt}, 128'd0);
        rst   = 1'b0;
        flush = 1'b0;
        offer(1'b0, 64'd0, 128'd0);
        tick();
        chk("rf_after_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rf_after_pc", {64'd0, bus.out_pc}, 128'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
